// File: rtl/text_fetch_sequencer_pkg.sv
// text_mode_pkg: shared constants and fetch-state types for the text-mode scanline fetcher
package text_mode_pkg;
   localparam int COLS = 80;
   localparam int ROWS = 30;
   localparam int CHAR_H = 16;
   localparam int CHAR_H_LOG2 = 4;
   localparam int LINES = ROWS * CHAR_H;
   localparam logic [15:0] FONT_BASE = 16'h2000;
   localparam int CHAR_ADDR_W = 13;
   localparam int FONT_ADDR_W = 12;
   typedef enum logic [2:0] {IDLE, CADDR, CWAIT, FADDR, FWAIT, OUT} fetch_state_e;
   typedef enum logic {PH_CHAR, PH_FONT} phase_e;
endpackage

// File: rtl/text_fetch_sequencer_if.sv
// text_fetch_sequencer_if: timing-generator start, memory read port and glyph byte stream
interface text_fetch_sequencer_if;
   logic        start;
   logic [8:0]  line;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [6:0]  out_col;
   logic        out_last;
   logic        busy;
   logic        line_done;
   modport master (output start, line, rd_data, out_ready,
                   input rd_addr, out_valid, out_data, out_col, out_last, busy, line_done);
   modport slave (input start, line, rd_data, out_ready,
                  output rd_addr, out_valid, out_data, out_col, out_last, busy, line_done);
endinterface

// File: rtl/text_fetch_sequencer_addr_gen.sv
// text_addr_gen: maps fetch phase and row/column/code/line indices to the shared read address
module text_addr_gen
   import text_mode_pkg::*;
(
   input  logic [4:0]  trow_i,
   input  logic [6:0]  col_i,
   input  logic [7:0]  code_i,
   input  logic [3:0]  lrow_i,
   input  phase_e      phase_i,
   output logic [15:0] addr_o
);
   logic [CHAR_ADDR_W-1:0] char_addr;
   logic [FONT_ADDR_W-1:0] font_off;
   assign char_addr = CHAR_ADDR_W'(trow_i) * CHAR_ADDR_W'(COLS) + CHAR_ADDR_W'(col_i);
   assign font_off = {code_i, lrow_i};
   assign addr_o = (phase_i == PH_FONT) ? (FONT_BASE | 16'(font_off)) : 16'(char_addr);
endmodule

// File: rtl/text_fetch_sequencer.sv
// text_fetch_sequencer: per-column character-code then font-row reads, streamed out as glyph bytes
module text_fetch_sequencer
   import text_mode_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input logic                    clk,
   input logic                    rst,
   text_fetch_sequencer_if.slave  bus
);
   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   fetch_state_e state_q, state_d;
   logic [4:0]    trow_q, trow_d;
   logic [3:0]    lrow_q, lrow_d;
   logic [6:0]    col_q, col_d;
   logic [7:0]    code_q, code_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [15:0]   rd_addr_q, rd_addr_d, gen_addr;
   logic [7:0]    out_data_q, out_data_d;
   logic [6:0]    out_col_q, out_col_d;
   logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic          busy_q, busy_d, line_done_q, line_done_d;
   logic          lat_end;

   // Address is generated from next-state indices so it is registered on entry to CADDR/FADDR
   text_addr_gen u_addr (
      .trow_i  (trow_d),
      .col_i   (col_d),
      .code_i  (code_d),
      .lrow_i  (lrow_d),
      .phase_i ((state_d == FADDR) ? PH_FONT : PH_CHAR),
      .addr_o  (gen_addr)
   );

   assign lat_end = (lat_q == LW'(MEM_LAT - 1));

   always_comb begin
      state_d = state_q;
      trow_d = trow_q;
      lrow_d = lrow_q;
      col_d = col_q;
      code_d = code_q;
      lat_d = lat_q;
      out_data_d = out_data_q;
      out_col_d = out_col_q;
      out_valid_d = out_valid_q;
      out_last_d = out_last_q;
      busy_d = busy_q;
      line_done_d = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            if (bus.line < 9'(LINES)) begin
               trow_d = bus.line[8:CHAR_H_LOG2];
               lrow_d = bus.line[CHAR_H_LOG2-1:0];
               col_d = '0;
               busy_d = 1'b1;
               state_d = CADDR;
            end else line_done_d = 1'b1;
         end
         CADDR: begin
            lat_d = '0;
            state_d = CWAIT;
         end
         CWAIT: begin
            lat_d = lat_q + LW'(1);
            if (lat_end) begin
               code_d = bus.rd_data;
               state_d = FADDR;
            end
         end
         FADDR: begin
            lat_d = '0;
            state_d = FWAIT;
         end
         FWAIT: begin
            lat_d = lat_q + LW'(1);
            if (lat_end) begin
               out_data_d = bus.rd_data;
               out_valid_d = 1'b1;
               out_col_d = col_q;
               out_last_d = (col_q == 7'(COLS - 1));
               state_d = OUT;
            end
         end
         OUT: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
               line_done_d = 1'b1;
               busy_d = 1'b0;
               state_d = IDLE;
            end else begin
               col_d = col_q + 7'd1;
               state_d = CADDR;
            end
         end
         default: state_d = IDLE;
      endcase
      rd_addr_d = (state_d == CADDR || state_d == FADDR) ? gen_addr : rd_addr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         trow_q <= '0;
         lrow_q <= '0;
         col_q <= '0;
         code_q <= '0;
         lat_q <= '0;
         rd_addr_q <= '0;
         out_data_q <= '0;
         out_col_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q <= 1'b0;
         busy_q <= 1'b0;
         line_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         trow_q <= trow_d;
         lrow_q <= lrow_d;
         col_q <= col_d;
         code_q <= code_d;
         lat_q <= lat_d;
         rd_addr_q <= rd_addr_d;
         out_data_q <= out_data_d;
         out_col_q <= out_col_d;
         out_valid_q <= out_valid_d;
         out_last_q <= out_last_d;
         busy_q <= busy_d;
         line_done_q <= line_done_d;
      end
   end

   assign bus.rd_addr = rd_addr_q;
   assign bus.out_data = out_data_q;
   assign bus.out_col = out_col_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last = out_last_q;
   assign bus.busy = busy_q;
   assign bus.line_done = line_done_q;
endmodule
